// File: rtl/rf_pkg.sv
// Shared constants, types and the write-port priority helper for the
// multi-ported register file.
package rf_pkg;

   localparam int RF_DATA_W    = 32;
   localparam int RF_ADDR_W    = 5;
   localparam int RF_NUM_RD    = 2;
   localparam int RF_NUM_WR    = 2;
   localparam int RF_MAX_PORTS = 4;

   typedef logic [1:0] port_idx_t;

   typedef struct packed {
      logic      hit;
      port_idx_t port;
   } rf_wr_sel_t;

   // Highest-numbered requesting port wins; hit is clear when nobody asks.
   function automatic rf_wr_sel_t rf_pick_writer(input logic [RF_MAX_PORTS-1:0] match);
      rf_wr_sel_t sel;
      sel.hit  = |match;
      sel.port = '0;
      for (int k = 0; k < RF_MAX_PORTS; k++) begin
         if (match[k]) begin
            sel.port = port_idx_t'(k);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array mux, same-cycle write forwarding and
// register-zero masking.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_WR   = RF_NUM_WR,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic [DATA_W-1:0]        mem [2**ADDR_W],
   input  logic [ADDR_W-1:0]        pr,
   input  logic                     reset,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0]        rd
);

   always_comb begin
      logic [NUM_WR-1:0] match;
      rf_wr_sel_t        sel;
      match = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         match[k] = wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == pr);
      end
      sel = rf_pick_writer(RF_MAX_PORTS'(match));

      rd = mem[pr];
      // Forwarding is disabled during reset so the bus shows pre-reset contents.
      if ((BYPASS != 0) && !reset && sel.hit) begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (int'(sel.port) == k) begin
               rd = wr_data[k*DATA_W +: DATA_W];
            end
         end
      end
      if ((ZERO_REG != 0) && (pr == '0)) begin
         rd = '0;
      end
   end

endmodule

// File: rtl/mp_reg_file.sv
// Multi-ported register file: NUM_WR prioritised write ports, NUM_RD
// combinational read ports with optional forwarding and hardwired zero.
module mp_reg_file
   import rf_pkg::*;
#(
   parameter int DATA_W     = RF_DATA_W,
   parameter int ADDR_W     = RF_ADDR_W,
   parameter int NUM_RD     = RF_NUM_RD,
   parameter int NUM_WR     = RF_NUM_WR,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1,
   parameter int INIT_INDEX = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_WR-1:0]        write,
   input  logic [NUM_WR*ADDR_W-1:0] WR,
   input  logic [NUM_WR*DATA_W-1:0] WD,
   input  logic [NUM_RD*ADDR_W-1:0] PR,
   output logic [NUM_RD*DATA_W-1:0] RD
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // Per-entry write resolution: when ports collide the highest one wins.
   always_comb begin
      logic [NUM_WR-1:0] match;
      rf_wr_sel_t        sel;
      for (int i = 0; i < DEPTH; i++) begin
         match = '0;
         for (int k = 0; k < NUM_WR; k++) begin
            match[k] = write[k] && (WR[k*ADDR_W +: ADDR_W] == ADDR_W'(i));
         end
         sel = rf_pick_writer(RF_MAX_PORTS'(match));

         mem_d[i] = mem_q[i];
         if (sel.hit && !((ZERO_REG != 0) && (i == 0))) begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (int'(sel.port) == k) begin
                  mem_d[i] = WD[k*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset) begin
            mem_q[i] <= (INIT_INDEX != 0) ? DATA_W'(unsigned'(i)) : '0;
         end else begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
         ) u_rd (
            .mem     (mem_q),
            .pr      (PR[gi*ADDR_W +: ADDR_W]),
            .reset   (reset),
            .wr_en   (write),
            .wr_addr (WR),
            .wr_data (WD),
            .rd      (RD[gi*DATA_W +: DATA_W])
         );
      end
   endgenerate

endmodule

// File: tb/tb_mp_reg_file.sv
// Directed bench: one forwarding instance and one non-forwarding instance
// share all inputs; expected read values are hand-computed per vector.
module tb_mp_reg_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  write;
   logic [9:0]  WR;
   logic [63:0] WD;
   logic [9:0]  PR;
   logic [63:0] RD;
   logic [63:0] RD_nb;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mp_reg_file dut (
      .clk(clk), .reset(reset), .write(write), .WR(WR), .WD(WD), .PR(PR), .RD(RD)
   );

   mp_reg_file #(.BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .write(write), .WR(WR), .WD(WD), .PR(PR), .RD(RD_nb)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  wen;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [4:0]  pa0;
      logic [4:0]  pa1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] n0;
      logic [31:0] n1;
   } vec_t;

   localparam int NV = 14;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] n0, input logic [31:0] n1);
      chk({tag, " byp.rd0"}, RD[31:0], e0);
      chk({tag, " byp.rd1"}, RD[63:32], e1);
      chk({tag, " nb.rd0"}, RD_nb[31:0], n0);
      chk({tag, " nb.rd1"}, RD_nb[63:32], n1);
      $display("txn %s: rd=%0d/%0d nb=%0d/%0d", tag, RD[31:0], RD[63:32], RD_nb[31:0], RD_nb[63:32]);
   endtask

   initial begin
      //          rst wen  wa0 wd0    wa1 wd1   pa0 pa1  e0     e1    n0     n1
      vec[0]  = '{0, 2'b01, 4,  31,    0,  0,    4,  5,   31,    5,    4,     5};
      vec[1]  = '{0, 2'b00, 0,  0,     0,  0,    4,  4,   31,    31,   31,    31};
      vec[2]  = '{0, 2'b11, 9,  100,   9,  200,  9,  9,   200,   200,  9,     9};
      vec[3]  = '{0, 2'b00, 0,  0,     0,  0,    9,  9,   200,   200,  200,   200};
      vec[4]  = '{0, 2'b01, 0,  55,    0,  0,    0,  3,   0,     3,    0,     3};
      vec[5]  = '{0, 2'b00, 0,  0,     0,  0,    0,  0,   0,     0,    0,     0};
      vec[6]  = '{0, 2'b10, 0,  0,     7,  77,   7,  6,   77,    6,    7,     6};
      vec[7]  = '{0, 2'b11, 10, 1000,  11, 1100, 11, 10,  1100,  1000, 11,    10};
      vec[8]  = '{0, 2'b11, 12, 43690, 13, 5,    10, 11,  1000,  1100, 1000,  1100};
      vec[9]  = '{0, 2'b00, 0,  0,     0,  0,    12, 13,  43690, 5,    43690, 5};
      vec[10] = '{0, 2'b00, 0,  0,     0,  0,    7,  31,  77,    31,   77,    31};
      // reset with a concurrent write: no forwarding, write discarded
      vec[11] = '{1, 2'b10, 0,  0,     7,  99,   4,  7,   31,    77,   31,    77};
      vec[12] = '{0, 2'b00, 0,  0,     0,  0,    4,  7,   4,     7,    4,     7};
      vec[13] = '{0, 2'b00, 0,  0,     0,  0,    9,  12,  9,     12,   9,     12};

      reset = 1'b1;
      write = 2'b00;
      WR    = '0;
      WD    = '0;
      PR    = {5'd8, 5'd6};
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_all("reset idx", 6, 8, 6, 8);
      PR = {5'd8, 5'd0};
      #1;
      chk_all("reset zero", 0, 8, 0, 8);
      @(posedge clk);
      #1;

      for (int v = 0; v < NV; v++) begin
         reset = vec[v].rst;
         write = vec[v].wen;
         WR    = {vec[v].wa1, vec[v].wa0};
         WD    = {vec[v].wd1, vec[v].wd0};
         PR    = {vec[v].pa1, vec[v].pa0};
         @(negedge clk);
         chk_all($sformatf("vec%0d", v), vec[v].e0, vec[v].e1, vec[v].n0, vec[v].n1);
         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mp_reg_file.md
MP_REG_FILE -- requirements
Module: mp_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter NUM_WR, default 2, number of write ports (1..2).
REQ-005 SHALL have parameter ZERO_REG, default 1; 1 = register 0 reads 0 and ignores writes.
REQ-006 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding.
REQ-007 SHALL have parameter INIT_INDEX, default 1; 1 = reset loads register i with value i, 0 = reset loads 0.
REQ-008 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-009 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-010 SHALL have port write  input  NUM_WR  per-port write enable; bit k qualifies write port k.
REQ-011 SHALL have port WR  input  NUM_WR*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port WD  input  NUM_WR*DATA_W  write data, port k at bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port PR  input  NUM_RD*ADDR_W  read addresses, port j at bits [j*ADDR_W +: ADDR_W].
REQ-014 SHALL have port RD  output  NUM_RD*DATA_W  read data, port j at bits [j*DATA_W +: DATA_W].

Function
REQ-015 SHALL perform reads combinationally: RD port j reflects the stored value of PR port j with zero-cycle latency.
REQ-016 SHALL commit write port k at the rising edge of clk when write[k]=1 and reset=0.
REQ-017 SHALL, when two write ports target the same address in one cycle, commit only the highest-numbered enabled port.
REQ-018 SHALL, with ZERO_REG=1, drop writes to address 0 and drive RD=0 for any read of address 0, bypass included.
REQ-019 SHALL, with BYPASS=1 and reset=0, drive RD port j with WD of the winning enabled write port whose WR equals PR port j (REQ-017 priority), otherwise the stored value.
REQ-020 SHALL, with BYPASS=0, drive the pre-edge stored value during a same-address write; the new value appears after the edge.
REQ-021 SHALL apply bypass to every read port independently; multiple read ports on the same address see identical data.
REQ-022 SHALL leave all non-written registers unchanged every cycle.
REQ-023 SHALL add no extra state beyond the 2**ADDR_W x DATA_W storage array.

Reset
REQ-024 SHALL, on a rising edge with reset=1, load every register with its index (zero-extended/truncated to DATA_W) when INIT_INDEX=1, or 0 when INIT_INDEX=0; register 0 = 0 when ZERO_REG=1.
REQ-025 SHALL give reset priority over all writes in the same cycle; those writes are discarded.
REQ-026 SHALL suppress bypass while reset=1; RD shows stored (pre-reset) values until the reset edge, then reset values.
REQ-027 SHALL drive RD, after the first reset edge with PR held, to the reset value of each addressed register.

Structure
REQ-028 SHALL place default DATA_W/ADDR_W/NUM_RD/NUM_WR constants and a write-port priority helper function in shared package rf_pkg.
REQ-029 SHALL instantiate sub-module rf_read_port once per read port (generate loop), containing array mux, bypass compare/select and zero-register masking.
REQ-030 SHALL implement write priority inside mp_reg_file; no other sub-modules.

Verification
REQ-031 Reset with INIT_INDEX=1, PR0=6, PR1=8, write=0 -> RD0=6, RD1=8 after reset edge; PR0=0 -> RD0=0.
REQ-032 write[0]=1, WR0=4, WD0=31, BYPASS=1, PR0=4 -> RD0=31 same cycle before edge; write=0 next cycle -> RD0 stays 31.
REQ-033 Same as REQ-032 with BYPASS=0 -> RD0=4 before edge, 31 after edge.
REQ-034 write=2'b11, WR0=WR1=9, WD0=100, WD1=200, PR0=9 -> RD0=200 via bypass; after edge RD0=200; register 9 never holds 100.
REQ-035 write[0]=1, WR0=0, WD0=55, PR0=0, ZERO_REG=1 -> RD0=0 before and after edge.
REQ-036 Register 7 written to 77, then reset=1 with write[1]=1, WR1=7, WD1=99, PR1=7 -> RD1=77 before edge (no bypass), RD1=7 after edge.
